// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle ARM control unit: FSM state encodings,
// ALUControl codes, instruction Op classes, ResultSrc / ALUSrcB selector codes,
// data-processing Funct[4:1] command codes, and the data-processing ALU decode
// helper.
// ---------------------------------------------------------------------------
package mc_pkg;

  localparam int STATE_W    = 4;
  localparam int ALU_CTRL_W = 2;

  // Ten states fit in the 4-bit state register; codes 10..15 are unused.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_ILL = 2'b11
  } op_t;

  // ResultSrc selector
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcB selector
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Data-processing commands, Funct[4:1]
  localparam logic [3:0] FN_AND = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_ADD = 4'b0100;
  localparam logic [3:0] FN_CMP = 4'b1010;
  localparam logic [3:0] FN_ORR = 4'b1100;

  // Data-processing command to ALU operation. Unsupported commands fall back
  // to ADD so the datapath always sees a defined operation.
  function automatic alu_ctrl_t dp_alu(input logic [3:0] fn);
    case (fn)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_CMP:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_ORR:  return ALU_ORR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_if.sv
// ---------------------------------------------------------------------------
// mc_if
// Bundle between the control unit and the shared datapath / unified memory.
//   Instruction fields : Cond[3:0], Op[1:0], Funct[5:0], Rd[3:0]  (from IR)
//   Status             : ALUFlags[3:0] (NZCV, current cycle), MemReady
//   Controls           : PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
//                        ResultSrc[1:0], ALUSrcA, ALUSrcB[1:0], ImmSrc[1:0],
//                        RegSrc[1:0], ALUControl, Illegal, State (debug)
// master : the control unit (reads fields/status, drives controls)
// slave  : the datapath side (drives fields/status, reads controls)
// ---------------------------------------------------------------------------
interface mc_if;
  import mc_pkg::*;

  logic [3:0]            Cond;
  logic [1:0]            Op;
  logic [5:0]            Funct;
  logic [3:0]            Rd;
  logic [3:0]            ALUFlags;
  logic                  MemReady;

  logic                  PCWrite;
  logic                  AdrSrc;
  logic                  MemWrite;
  logic                  IRWrite;
  logic                  RegWrite;
  logic [1:0]            ResultSrc;
  logic                  ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [1:0]            ImmSrc;
  logic [1:0]            RegSrc;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic                  Illegal;
  logic [STATE_W-1:0]    State;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Illegal, State
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Illegal, State
  );

endinterface

// File: rtl/cond_logic.sv
// ---------------------------------------------------------------------------
// cond_logic
// Holds the architectural NZCV flags and the per-instruction condition result.
//   clk, reset   : clock, asynchronous active-low reset
//   cond         : Cond field of the current instruction
//   alu_flags    : NZCV produced by the ALU this cycle
//   decode_en    : capture condcheck(cond, flags) into cond_ex_q
//   flag_we_nz   : update N and Z from alu_flags
//   flag_we_cv   : update C and V from alu_flags
//   cond_ex_q    : registered "instruction executes" bit
// ---------------------------------------------------------------------------
module cond_logic
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       decode_en,
  input  logic       flag_we_nz,
  input  logic       flag_we_cv,
  output logic       cond_ex_q
);

  logic [3:0] flags;  // {N, Z, C, V}

  function automatic logic condcheck(input logic [3:0] c, input logic [3:0] nzcv);
    logic n, z, cf, v;
    {n, z, cf, v} = nzcv;
    case (c)
      4'b0000: return z;                     // EQ
      4'b0001: return !z;                    // NE
      4'b0010: return cf;                    // CS
      4'b0011: return !cf;                   // CC
      4'b0100: return n;                     // MI
      4'b0101: return !n;                    // PL
      4'b0110: return v;                     // VS
      4'b0111: return !v;                    // VC
      4'b1000: return cf && !z;              // HI
      4'b1001: return !cf || z;              // LS
      4'b1010: return n == v;                // GE
      4'b1011: return n != v;                // LT
      4'b1100: return !z && (n == v);        // GT
      4'b1101: return z || (n != v);         // LE
      default: return 1'b1;                  // AL, and 1111 treated as always
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags     <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      if (decode_en)  cond_ex_q  <= condcheck(cond, flags);
      if (flag_we_nz) flags[3:2] <= alu_flags[3:2];
      if (flag_we_cv) flags[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
// Multicycle control unit: steps one shared datapath and one unified
// instruction/data memory through fetch, decode, execute, memory and
// writeback, and evaluates ARM condition codes against the held NZCV flags.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low; abandons any in-flight instruction
//   bus    : mc_if.master -- instruction fields and status in, controls out
// Cycle counts with MemReady=1: data-proc 4, CMP 3, LDR 5, STR 4, B 3.
// ---------------------------------------------------------------------------
module mc_controller
  import mc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mc_if.master bus
);

  state_t    state;
  logic      cond_ex_q;
  logic      rd_is_pc;
  logic      is_cmp;
  alu_ctrl_t exec_alu;

  // Raw decode before reset gating
  logic      pcw, irw, regw, memw;
  logic      adr_src, alu_src_a, illegal;
  logic [1:0] result_src, alu_src_b;
  alu_ctrl_t alu_ctrl;

  logic      flag_we_nz, flag_we_cv;

  assign rd_is_pc = (bus.Rd == 4'd15);
  assign is_cmp   = (bus.Funct[4:1] == FN_CMP);
  assign exec_alu = dp_alu(bus.Funct[4:1]);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      unique case (state)
        S_FETCH:    if (bus.MemReady) state <= S_DECODE;
        S_DECODE: begin
          case (op_t'(bus.Op))
            OP_DP:   state <= bus.Funct[5] ? S_EXECI : S_EXECR;
            OP_MEM:  state <= S_MEMADR;
            OP_BR:   state <= S_BRANCH;
            default: state <= S_FETCH;            // undefined class: skip it
          endcase
        end
        S_MEMADR:   state <= bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (bus.MemReady) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        // A suppressed store issues no access, so there is nothing to wait for.
        S_MEMWRITE: if (!cond_ex_q || bus.MemReady) state <= S_FETCH;
        S_EXECR,
        S_EXECI:    state <= is_cmp ? S_FETCH : S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode. FETCH and memory states must react to MemReady in the same
  // cycle, so the controls are decoded from the state register rather than
  // registered a cycle ahead.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output is given a default first so that no
    // state leaves a signal unassigned and infers a latch.
    pcw        = 1'b0;
    irw        = 1'b0;
    regw       = 1'b0;
    memw       = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RD2;
    result_src = RES_ALURESULT;
    alu_ctrl   = ALU_ADD;
    illegal    = 1'b0;

    unique case (state)
      S_FETCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_FOUR;
        irw       = bus.MemReady;
        pcw       = bus.MemReady;
      end
      S_DECODE: begin
        // PC+4 again here so R15 reads PC+8.
        alu_src_a = 1'b1;
        alu_src_b = SRCB_FOUR;
        illegal   = (bus.Op == OP_ILL);
      end
      S_MEMADR: begin
        alu_src_b = SRCB_IMM;
        alu_ctrl  = bus.Funct[3] ? ALU_ADD : ALU_SUB;   // U bit: add/sub offset
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        regw       = cond_ex_q;
        pcw        = cond_ex_q && rd_is_pc;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        memw    = cond_ex_q;
      end
      S_EXECR: begin
        alu_ctrl = exec_alu;
      end
      S_EXECI: begin
        alu_src_b = SRCB_IMM;
        alu_ctrl  = exec_alu;
      end
      S_ALUWB: begin
        // Writes to R15 go to the PC register instead of the register file.
        result_src = RES_ALUOUT;
        regw       = cond_ex_q && !rd_is_pc;
        pcw        = cond_ex_q && rd_is_pc;
      end
      S_BRANCH: begin
        alu_src_b = SRCB_IMM;
        pcw       = cond_ex_q;
      end
      default: ;
    endcase
  end

  // Flags update only for an executing S-suffixed data-processing op; logical
  // ops leave C and V alone.
  assign flag_we_nz = ((state == S_EXECR) || (state == S_EXECI)) &&
                      bus.Funct[0] && cond_ex_q;
  assign flag_we_cv = flag_we_nz && ((alu_ctrl == ALU_ADD) || (alu_ctrl == ALU_SUB));

  cond_logic u_cond (
    .clk        (clk),
    .reset      (reset),
    .cond       (bus.Cond),
    .alu_flags  (bus.ALUFlags),
    .decode_en  (state == S_DECODE),
    .flag_we_nz (flag_we_nz),
    .flag_we_cv (flag_we_cv),
    .cond_ex_q  (cond_ex_q)
  );

  // Enables are masked while reset is held: the FSM already sits in FETCH
  // then, and an asserted MemReady must not load IR or PC.
  assign bus.PCWrite    = reset && pcw;
  assign bus.IRWrite    = reset && irw;
  assign bus.RegWrite   = reset && regw;
  assign bus.MemWrite   = reset && memw;

  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_ctrl;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {(bus.Op == OP_MEM) && !bus.Funct[0], bus.Op == OP_BR};
  assign bus.Illegal    = illegal;
  assign bus.State      = state;

endmodule
